// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: per-channel FSM state
// encoding, default timing constants and a small elaboration-time helper.
// Optional auto-repeat is enabled with the BUTTON_CONDITIONER_AUTOREPEAT_EN macro.
package button_pkg;

    // Per-channel press FSM. ST_REPEAT_EMIT is only reachable when
    // auto-repeat is compiled in.
    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_EMIT  = 2'd1,
        ST_HELD        = 2'd2,
        ST_REPEAT_EMIT = 2'd3
    } btn_state_e;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat spacing at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

    // Larger of two integers, used to size a counter shared by two limits.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One push-button channel: 2-FF synchronizer, debounce counter and press FSM.
// Produces the debounced level and a one-cycle-early pulse request that the
// top level registers. With BUTTON_CONDITIONER_AUTOREPEAT_EN defined, a held
// button also requests auto-repeat pulses.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic stable_o,
    output logic emit_req_o
);

    // Reject parameter values the counters cannot honour.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the next differing edge completes the debounce.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            stable_q;
    logic            stable_d;
    btn_state_e      state_q;

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_SAT     = RPT_W'(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // Cycles elapsed since the last emitted pulse of this press.
    logic [RPT_W-1:0] rpt_cnt_q;
    // Set once the first auto-repeat of the current press has fired, so the
    // shorter repeat period applies from then on.
    logic             rpt_seen_q;
    logic             rpt_due;

    assign rpt_due = (rpt_cnt_q >= (rpt_seen_q ? PERIOD_LAST : DELAY_LAST));
`endif

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so sync2_q takes the pre-edge sync1_q; a
            // blocking assignment would collapse the chain into a single flop.
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: count edges that disagree with the stable level,
    // restart on any agreement, flip the level once the run is long enough.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        db_cnt_d = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (db_cnt_q >= DB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q <= '0;
            stable_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            stable_q <= stable_d;
        end
    end

    // Press FSM: one emit state per press, plus optional repeat scheduling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RELEASED;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rpt_cnt_q  <= '0;
            rpt_seen_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    if (stable_q) begin
                        state_q <= ST_PRESS_EMIT;
                    end
                end
                ST_PRESS_EMIT: begin
                    state_q <= ST_HELD;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    rpt_cnt_q  <= RPT_W'(1);
                    rpt_seen_q <= 1'b0;
`endif
                end
                ST_HELD: begin
                    if (!stable_q) begin
                        state_q <= ST_RELEASED;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                        rpt_cnt_q <= '0;
                    end else if (rpt_due) begin
                        state_q <= ST_REPEAT_EMIT;
                    end else if (rpt_cnt_q != RPT_SAT) begin
                        rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
`endif
                    end
                end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                ST_REPEAT_EMIT: begin
                    state_q    <= ST_HELD;
                    rpt_cnt_q  <= RPT_W'(1);
                    rpt_seen_q <= 1'b1;
                end
`endif
                default: begin
                    state_q <= ST_RELEASED;
                end
            endcase
        end
    end

    // Pulse request: high in the cycle before the FSM enters an emit state,
    // so the registered output at the top coincides with that emit state.
    always_comb begin
        emit_req_o = 1'b0;
        if (state_q == ST_RELEASED && stable_q) begin
            emit_req_o = 1'b1;
        end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        if (state_q == ST_HELD && stable_q && rpt_due) begin
            emit_req_o = 1'b1;
        end
`endif
    end

    assign stable_o = stable_q;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Up/down push-button front end: two debounced channels, a mutual-exclusion
// gate and registered one-cycle request pulses u/d.
// Build option: define BUTTON_CONDITIONER_AUTOREPEAT_EN for auto-repeat.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic u,
    output logic d,
    output logic up_held,
    output logic down_held
);

    logic up_req;
    logic down_req;
    logic up_stable;
    logic down_stable;
    logic u_q;
    logic d_q;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_up_channel (
        .clk        (clk),
        .reset      (reset),
        .btn_raw_i  (btn_up_raw),
        .stable_o   (up_stable),
        .emit_req_o (up_req)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_down_channel (
        .clk        (clk),
        .reset      (reset),
        .btn_raw_i  (btn_down_raw),
        .stable_o   (down_stable),
        .emit_req_o (down_req)
    );

    // Register the pulses; simultaneous requests cancel each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            u_q <= 1'b0;
            d_q <= 1'b0;
        end else begin
            u_q <= up_req & ~down_req;
            d_q <= down_req & ~up_req;
        end
    end

    assign u         = u_q;
    assign d         = d_q;
    assign up_held   = up_stable;
    assign down_held = down_stable;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with short timing parameters.
// A behavioural model (sliding window of synchronized samples plus scheduled
// pulse times) predicts every output each cycle; directed scenarios add
// explicit latency and pulse-count checks. Define
// BUTTON_CONDITIONER_AUTOREPEAT_EN to exercise auto-repeat as well.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk;
    logic reset;
    logic btn_up_raw;
    logic btn_down_raw;
    logic u;
    logic d;
    logic up_held;
    logic down_held;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .u            (u),
        .d            (d),
        .up_held      (up_held),
        .down_held    (down_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int  edge_no = 0;
    bit  m_valid = 1'b0;
    bit  m_s1 [2];
    bit  m_s2 [2];
    bit  m_stable [2];
    bit  m_hist [2][DB];   // last DB synchronized samples seen by the debouncer
    int  m_due [2];        // edge number after which a pulse is expected, -1 none
    bit  m_first [2];      // next repeat is the first of this press
    bit  exp_u = 1'b0;
    bit  exp_d = 1'b0;

    always @(posedge clk) begin : ref_model
        bit raw [2];
        bit req [2];
        bit v;
        bit all_diff;
        edge_no++;
        raw[0] = btn_up_raw;
        raw[1] = btn_down_raw;
        if (reset) begin
            m_valid = 1'b1;
            exp_u   = 1'b0;
            exp_d   = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_s1[c]     = 1'b0;
                m_s2[c]     = 1'b0;
                m_stable[c] = 1'b0;
                m_due[c]    = -1;
                m_first[c]  = 1'b0;
                for (int i = 0; i < DB; i++) m_hist[c][i] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) req[c] = (m_due[c] == edge_no);
            exp_u = req[0] && !req[1];
            exp_d = req[1] && !req[0];
            for (int c = 0; c < 2; c++) begin
                if (req[c]) begin
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    m_due[c]   = edge_no + (m_first[c] ? RD : RP);
                    m_first[c] = 1'b0;
`else
                    m_due[c]   = -1;
`endif
                end
                v       = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
                for (int i = 0; i < DB - 1; i++) m_hist[c][i] = m_hist[c][i+1];
                m_hist[c][DB-1] = v;
                all_diff = 1'b1;
                for (int i = 0; i < DB; i++) if (m_hist[c][i] == m_stable[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable[c] = !m_stable[c];
                    for (int i = 0; i < DB; i++) m_hist[c][i] = m_stable[c];
                    if (m_stable[c]) begin
                        m_due[c]   = edge_no + 1;
                        m_first[c] = 1'b1;
                    end else begin
                        m_due[c] = -1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison and event tracking ----------------
    int u_count = 0;
    int d_count = 0;
    int last_u_edge = -1;
    int up_rise_edge = -1;
    int up_fall_edge = -1;
    int u_edges [$];
    logic prev_up_held = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("outs{u,d,up_held,down_held}", {28'd0, u, d, up_held, down_held},
                  {28'd0, exp_u, exp_d, m_stable[0], m_stable[1]});
            if (u === 1'b1) begin
                u_count++;
                last_u_edge = edge_no;
                u_edges.push_back(edge_no);
            end
            if (d === 1'b1) d_count++;
            if (up_held === 1'b1 && prev_up_held !== 1'b1) up_rise_edge = edge_no;
            if (up_held !== 1'b1 && prev_up_held === 1'b1) up_fall_edge = edge_no;
            prev_up_held = up_held;
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic drive(input bit up, input bit dn, input int n);
        for (int i = 0; i < n; i++) begin
            btn_up_raw   = up;
            btn_down_raw = dn;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 2);
        reset = 1'b0;
        drive(1'b0, 1'b0, 3);
    endtask

    task automatic clear_events();
        u_count      = 0;
        d_count      = 0;
        last_u_edge  = -1;
        up_rise_edge = -1;
        up_fall_edge = -1;
        u_edges.delete();
    endtask

    int e0;
    int rep_offs [5];

    initial begin
        reset        = 1'b1;
        btn_up_raw   = 1'b0;
        btn_down_raw = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_outs", {28'd0, u, d, up_held, down_held}, 32'd0);

        // Clean press: up_held after edge 6, single u after edge 7.
        e0 = edge_no;
        clear_events();
        drive(1'b1, 1'b0, 8);
        drive(1'b0, 1'b0, 20);
        check("press_u_edge", last_u_edge, e0 + 7);
        check("press_u_count", u_count, 1);
        check("press_held_rise", up_rise_edge, e0 + 6);
        check("press_d_count", d_count, 0);

        // Bounce 1,0,1,0 then held, followed by a bouncy release 0,1,0.
        do_reset();
        e0 = edge_no;
        clear_events();
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 6);
        drive(1'b0, 1'b0, 1);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 14);
        check("bounce_u_edge", last_u_edge, e0 + 11);
        check("bounce_u_count", u_count, 1);
        check("release_fall_edge", up_fall_edge, e0 + 18);
        check("release_d_count", d_count, 0);

        // Both buttons together: both held, no pulses at all.
        do_reset();
        clear_events();
        drive(1'b1, 1'b1, 10);
        check("both_held", {30'd0, up_held, down_held}, 32'd3);
        drive(1'b1, 1'b1, 4);
        drive(1'b0, 1'b0, 12);
        check("both_u_count", u_count, 0);
        check("both_d_count", d_count, 0);

        // Reset at debounce count 2 with the button held: full restart.
        do_reset();
        e0 = edge_no;
        clear_events();
        drive(1'b1, 1'b0, 4);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1);
        check("mid_reset_outs", {28'd0, u, d, up_held, down_held}, 32'd0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 8);
        drive(1'b0, 1'b0, 12);
        check("restart_u_edge", last_u_edge, e0 + 12);
        check("restart_u_count", u_count, 1);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        // Auto-repeat: first pulse then +8, +11, +14, +17; none after release.
        do_reset();
        e0 = edge_no;
        clear_events();
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 30);
        rep_offs[0] = 0;
        rep_offs[1] = 8;
        rep_offs[2] = 11;
        rep_offs[3] = 14;
        rep_offs[4] = 17;
        check("repeat_u_count", u_count, 5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("repeat_edge_%0d", k),
                  (k < u_edges.size()) ? u_edges[k] : -1, e0 + 7 + rep_offs[k]);
        end
`endif

        // Randomized segments checked cycle by cycle against the model.
        do_reset();
        for (int s = 0; s < 120; s++) begin
            bit up;
            bit dn;
            int len;
            up  = 1'($urandom_range(0, 1));
            dn  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 24))
                                              : int'($urandom_range(1, 5));
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                drive(up, dn, 1);
                reset = 1'b0;
            end
            drive(up, dn, len);
        end
        drive(1'b0, 1'b0, 20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_button_conditioner
